fsm_input_conditioner: RTL and testbench

Input conditioning stage that sits directly upstream of the lab 9 two-bit-input state machine. It takes two raw, asynchronous switch/button levels, synchronizes each to `clk`, debounces each bit independently, and drives the clean 2-bit `x` bus consumed by the FSM's `x` input. It also emits a one-cycle change strobe for downstream logging and test observation.

---
 rtl/fsm_input_conditioner.sv | 85 ++++++++
 tb/tb_fsm_input_conditioner.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fsm_input_conditioner.sv
// Two-bit switch conditioner: 2-flop sync + per-bit debounce; x follows a stable level DEBOUNCE_CYCLES+1 edges after capture.
// No backpressure: free-running, x_change is a one-cycle registered strobe on any x update.
module fsm_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn_raw,
  output logic [1:0] x,
  output logic       x_change,
  output logic [1:0] bit_busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]            s1;
  logic [1:0]            s2;
  state_t                state_q [2];
  state_t                state_d [2];
  logic [1:0][CNT_W-1:0] cnt_q;
  logic [1:0][CNT_W-1:0] cnt_d;
  logic [1:0]            x_d;

  // Each bit runs its own debounce; a sample matching x while pending rejects the glitch.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      x_d[b]     = x[b];
      case (state_q[b])
        IDLE: begin
          if (s2[b] != x[b]) begin
            state_d[b] = PENDING;
            cnt_d[b]   = CNT_W'(1);
          end
        end
        PENDING: begin
          if (s2[b] == x[b]) begin
            state_d[b] = IDLE;
            cnt_d[b]   = '0;
          end else if (cnt_q[b] == CNT_LAST) begin
            x_d[b]     = s2[b];
            state_d[b] = IDLE;
            cnt_d[b]   = '0;
          end else begin
            cnt_d[b]   = cnt_q[b] + CNT_W'(1);
          end
        end
        default: begin
          state_d[b] = IDLE;
          cnt_d[b]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1         <= 2'b00;
      s2         <= 2'b00;
      x          <= 2'b00;
      x_change   <= 1'b0;
      cnt_q      <= '0;
      state_q[0] <= IDLE;
      state_q[1] <= IDLE;
    end else begin
      s1         <= btn_raw;
      s2         <= s1;
      x          <= x_d;
      x_change   <= (x_d != x);
      cnt_q      <= cnt_d;
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
    end
  end

  assign bit_busy = {state_q[1] == PENDING, state_q[0] == PENDING};

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Bench for fsm_input_conditioner: directed table, multi-cycle sequences, then random levels vs a history-window model.
module tb_fsm_input_conditioner;
  localparam int DC = 4;

  logic       clk;
  logic       reset;
  logic [1:0] btn_raw;
  logic [1:0] x;
  logic       x_change;
  logic [1:0] bit_busy;

  int n_vec = 0;
  int n_err = 0;

  fsm_input_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .x        (x),
    .x_change (x_change),
    .bit_busy (bit_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1);
  end

  // Reference: x[b] flips once the last DC synchronized samples all disagree with it;
  // a bit is busy when its latest sample still disagrees with x.
  logic [1:0] m_s1, m_s2, m_x, m_busy, flip;
  logic       m_chg;
  logic [1:0] hist[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 = 2'b00; m_s2 = 2'b00; m_x = 2'b00; m_busy = 2'b00; m_chg = 1'b0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > DC) void'(hist.pop_front());
      flip = 2'b00;
      for (int b = 0; b < 2; b++) begin
        if (hist.size() == DC) begin
          flip[b] = 1'b1;
          foreach (hist[i]) if (hist[i][b] == m_x[b]) flip[b] = 1'b0;
        end
      end
      m_x   = m_x ^ flip;
      m_chg = |flip;
      for (int b = 0; b < 2; b++) m_busy[b] = (hist[hist.size()-1][b] != m_x[b]);
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  end

  typedef struct {
    logic [1:0] btn;
    logic [1:0] ex;
    logic       ec;
    logic [1:0] eb;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [1:0] b, input logic [1:0] ex, input logic ec, input logic [1:0] eb);
    vec_t v;
    v.btn = b; v.ex = ex; v.ec = ec; v.eb = eb;
    tbl.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [1:0] ex, input logic ec, input logic [1:0] eb);
    n_vec++;
    if (x !== ex || x_change !== ec || bit_busy !== eb) begin
      n_err++;
      $display("FAIL %s: got x=%b x_change=%b bit_busy=%b, want x=%b x_change=%b bit_busy=%b",
               nm, x, x_change, bit_busy, ex, ec, eb);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with reset low and btn_raw already 11.
  task automatic release_expect_11(input string nm);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check(nm, (k >= 6) ? 2'b11 : 2'b00, (k == 6), (k >= 3 && k <= 5) ? 2'b11 : 2'b00);
    end
  endtask

  // Requires x == old and the synchronizer already settled on old.
  task automatic apply_hold(input string nm, input logic [1:0] nw, input logic [1:0] old, input int hold);
    btn_raw = nw;
    for (int k = 0; k < hold; k++) begin
      step();
      check(nm, (k >= 5) ? nw : old, (k == 5) && (nw != old), (k >= 2 && k <= 4) ? (nw ^ old) : 2'b00);
    end
  endtask

  initial begin
    reset   = 1'b0;
    btn_raw = 2'b11;

    // clean change 00 -> 10
    add(2'b10,2'b00,0,2'b00); add(2'b10,2'b00,0,2'b00); add(2'b10,2'b00,0,2'b10); add(2'b10,2'b00,0,2'b10);
    add(2'b10,2'b00,0,2'b10); add(2'b10,2'b10,1,2'b00); add(2'b10,2'b10,0,2'b00); add(2'b10,2'b10,0,2'b00);
    // 3-cycle glitch on bit 0
    add(2'b11,2'b10,0,2'b00); add(2'b11,2'b10,0,2'b00); add(2'b11,2'b10,0,2'b01); add(2'b10,2'b10,0,2'b01);
    add(2'b10,2'b10,0,2'b01); add(2'b10,2'b10,0,2'b00); add(2'b10,2'b10,0,2'b00);
    // back to 00
    add(2'b00,2'b10,0,2'b00); add(2'b00,2'b10,0,2'b00); add(2'b00,2'b10,0,2'b10); add(2'b00,2'b10,0,2'b10);
    add(2'b00,2'b10,0,2'b10); add(2'b00,2'b00,1,2'b00); add(2'b00,2'b00,0,2'b00); add(2'b00,2'b00,0,2'b00);
    // simultaneous 00 -> 11
    add(2'b11,2'b00,0,2'b00); add(2'b11,2'b00,0,2'b00); add(2'b11,2'b00,0,2'b11); add(2'b11,2'b00,0,2'b11);
    add(2'b11,2'b00,0,2'b11); add(2'b11,2'b11,1,2'b00); add(2'b11,2'b11,0,2'b00); add(2'b11,2'b11,0,2'b00);
    // simultaneous 11 -> 00
    add(2'b00,2'b11,0,2'b00); add(2'b00,2'b11,0,2'b00); add(2'b00,2'b11,0,2'b11); add(2'b00,2'b11,0,2'b11);
    add(2'b00,2'b11,0,2'b11); add(2'b00,2'b00,1,2'b00); add(2'b00,2'b00,0,2'b00); add(2'b00,2'b00,0,2'b00);
    // staggered 00 -> 01, then 01 -> 11 two cycles later
    add(2'b01,2'b00,0,2'b00); add(2'b01,2'b00,0,2'b00); add(2'b11,2'b00,0,2'b01); add(2'b11,2'b00,0,2'b01);
    add(2'b11,2'b00,0,2'b11); add(2'b11,2'b01,1,2'b10); add(2'b11,2'b01,0,2'b10); add(2'b11,2'b11,1,2'b00);
    add(2'b11,2'b11,0,2'b00);
    // back to 00 for the mid-reset sequence
    add(2'b00,2'b11,0,2'b00); add(2'b00,2'b11,0,2'b00); add(2'b00,2'b11,0,2'b11); add(2'b00,2'b11,0,2'b11);
    add(2'b00,2'b11,0,2'b11); add(2'b00,2'b00,1,2'b00); add(2'b00,2'b00,0,2'b00); add(2'b00,2'b00,0,2'b00);

    // Reset held with inputs high
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      step();
      check("reset_hold", 2'b00, 1'b0, 2'b00);
    end
    release_expect_11("reset_release");

    // FSM sweep 11, 10, 00, 01, then clear to 00
    apply_hold("sweep_11", 2'b11, 2'b11, 12);
    apply_hold("sweep_10", 2'b10, 2'b11, 12);
    apply_hold("sweep_00", 2'b00, 2'b10, 12);
    apply_hold("sweep_01", 2'b01, 2'b00, 12);
    apply_hold("sweep_clr", 2'b00, 2'b01, 12);

    foreach (tbl[i]) begin
      btn_raw = tbl[i].btn;
      step();
      check($sformatf("table_%0d", i), tbl[i].ex, tbl[i].ec, tbl[i].eb);
    end

    // Reset asserted mid-transition, just before E3
    btn_raw = 2'b11;
    step(); check("midrst_e0", 2'b00, 1'b0, 2'b00);
    step(); check("midrst_e1", 2'b00, 1'b0, 2'b00);
    step(); check("midrst_e2", 2'b00, 1'b0, 2'b11);
    reset = 1'b0;
    #1;
    check("midrst_async", 2'b00, 1'b0, 2'b00);
    @(negedge clk);
    step(); check("midrst_hold", 2'b00, 1'b0, 2'b00);
    release_expect_11("midrst_release");

    // Random levels with random hold times against the reference model
    for (int seg = 0; seg < 400; seg++) begin
      btn_raw = 2'($urandom_range(0, 3));
      for (int k = 0, h = $urandom_range(1, 8); k < h; k++) begin
        step();
        check("random", m_x, m_chg, m_busy);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
